// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Terminal value for a direction: MODULUS-1 counting up, 0 counting down.
  function automatic logic [31:0] term_val(input logic dir, input longint unsigned modulus);
    return (dir == DIR_UP) ? 32'(modulus - 64'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/counter_next_val.sv
// Next-count logic: step, terminal detect and boundary-step flag.
// MOD_UPDOWN_COUNTER_SAT_EN selects hold-at-terminal instead of wrapping.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  output logic [WIDTH-1:0] nxt,
  output logic             at_term,
  output logic             boundary
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  always_comb begin
    nxt      = count;
    at_term  = (count == WIDTH'(term_val(up_dn, MODULUS)));
    boundary = 1'b0;
    if (at_term) begin
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
      nxt      = count;
`else
      nxt      = (up_dn == DIR_UP) ? '0 : MAX_VAL;
      boundary = 1'b1;
`endif
    end else if (up_dn == DIR_UP) begin
      nxt = count + WIDTH'(1);
    end else begin
      nxt = count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with parallel load, terminal-count and wrap pulse.
// Build with MOD_UPDOWN_COUNTER_SAT_EN for saturating operation (wrap tied low).
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_clamped;
  logic             at_term;
  logic             boundary;

  counter_next_val #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count    (count),
    .up_dn    (up_dn),
    .nxt      (nxt),
    .at_term  (at_term),
    .boundary (boundary)
  );

  assign tc           = en & ~load & ~rst & at_term;
  assign load_clamped = (64'(load_val) >= MODULUS) ? MAX_VAL : load_val;

  // Priority: rst > load > en > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= tc & boundary;
      if (load) begin
        count <= load_clamped;
      end else if (en) begin
        count <= nxt;
      end
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter (WIDTH=4, MODULUS=10).
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, wrap;

  int checks   = 0;
  int failures = 0;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [3:0] v);
    rst = r; en = e; up_dn = u; load = l; load_val = v;
    #1;
  endtask

  task automatic load_to(input logic [3:0] v);
    drive(0, 0, 1, 1, v);
    tick();
    check("load_to", int'(count), int'(v));
  endtask

  initial begin
    drive(1, 1, 0, 0, 4'd0);
    // Reset held two cycles with en high; tc gated by rst even at count 0 down.
    tick();
    check("rst_c1_count", int'(count), 0);
    check("rst_c1_wrap", int'(wrap), 0);
    tick();
    check("rst_c2_count", int'(count), 0);
    check("rst_tc", int'(tc), 0);
    drive(0, 1, 1, 0, 4'd0);
    tick();
    check("first_en_count", int'(count), 1);
    check("first_en_wrap", int'(wrap), 0);

`ifndef MOD_UPDOWN_COUNTER_SAT_EN
    // Up wrap at 9.
    load_to(4'd9);
    drive(0, 1, 1, 0, 4'd0);
    check("up_tc", int'(tc), 1);
    tick();
    check("up_wrap_count", int'(count), 0);
    check("up_wrap_pulse", int'(wrap), 1);
    tick();
    check("up_after_count", int'(count), 1);
    check("up_after_wrap", int'(wrap), 0);

    // Down wrap at 0.
    drive(0, 1, 0, 0, 4'd0);
    tick();
    check("dn_to0_count", int'(count), 0);
    check("dn_tc", int'(tc), 1);
    tick();
    check("dn_wrap_count", int'(count), 9);
    check("dn_wrap_pulse", int'(wrap), 1);
    tick();
    check("dn_after_count", int'(count), 8);
    check("dn_after_wrap", int'(wrap), 0);
`endif

    // Load beats en; clamp out-of-range values.
    load_to(4'd9);
    drive(0, 1, 1, 1, 4'd12);
    check("load_en_tc", int'(tc), 0);
    tick();
    check("load_clamp12", int'(count), 9);
    check("load_en_wrap", int'(wrap), 0);
    drive(0, 1, 1, 1, 4'd10);
    tick();
    check("load_clamp10", int'(count), 9);
    drive(0, 0, 1, 1, 4'd5);
    tick();
    check("load_5", int'(count), 5);

    // Direction flip every enabled edge.
    load_to(4'd4);
    drive(0, 1, 1, 0, 4'd0); tick(); check("flip_1", int'(count), 5);
    drive(0, 1, 0, 0, 4'd0); tick(); check("flip_2", int'(count), 4);
    drive(0, 1, 1, 0, 4'd0); tick(); check("flip_3", int'(count), 5);
    drive(0, 1, 0, 0, 4'd0); tick(); check("flip_4", int'(count), 4);
    drive(0, 0, 0, 0, 4'd0); tick(); check("hold_1", int'(count), 4);
    tick(); check("hold_2", int'(count), 4);

    // Reset overrides load and en.
    drive(1, 1, 1, 1, 4'd7);
    tick();
    check("rst_override", int'(count), 0);
    check("rst_override_wrap", int'(wrap), 0);

    // Terminal not flagged when disabled.
    drive(0, 0, 0, 0, 4'd0);
    check("tc_en_low", int'(tc), 0);

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
    // Saturate at 9 going up, then reset mid-hold.
    load_to(4'd9);
    drive(0, 1, 1, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      check("sat_tc", int'(tc), 1);
      tick();
      check("sat_count", int'(count), 9);
      check("sat_wrap", int'(wrap), 0);
    end
    drive(1, 1, 1, 0, 4'd0);
    tick();
    check("sat_rst", int'(count), 0);
    drive(0, 1, 0, 0, 4'd0);
    check("sat_dn_tc", int'(tc), 1);
    tick();
    check("sat_dn_count", int'(count), 0);
    check("sat_dn_wrap", int'(wrap), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameters SHALL be as follows.
- WIDTH, default 8: count register width; legal range 2..32.
- MODULUS, default 2**WIDTH: count range is 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-002 Ports SHALL be as follows.
- clk  in  1  rising-edge clock; all state changes on posedge clk.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value for load.
- count  out  WIDTH  registered count value.
- tc  out  1  terminal-count flag, combinational.
- wrap  out  1  registered one-cycle event pulse.

Function
REQ-003 Each posedge SHALL update count by the first matching rule, in this priority order:
- rst: count = 0.
- load: count = load_val.
- en: count steps by one in the direction given by up_dn.
- otherwise: count holds.
REQ-004 Load SHALL clamp out-of-range values: if load_val >= MODULUS, count SHALL become MODULUS-1.
REQ-005 In up mode the next value SHALL be count+1, and count = MODULUS-1 SHALL step to 0.
REQ-006 In down mode the next value SHALL be count-1, and count = 0 SHALL step to MODULUS-1.
REQ-007 tc SHALL be high when en=1, load=0, rst=0, and count is at the terminal value for the current direction (MODULUS-1 for up, 0 for down).
REQ-008 wrap SHALL go high for exactly one cycle, on the cycle after a posedge where tc=1 and the boundary step of REQ-005/006 was taken; otherwise wrap SHALL be 0.
REQ-009 A change of up_dn SHALL take effect on the very next enabled edge, with no dead cycle.
REQ-010 load and en asserted together SHALL load only, with no step, and wrap SHALL be 0 on the following cycle.
REQ-011 Arithmetic SHALL be unsigned at WIDTH bits with no intermediate overflow, including when MODULUS = 2**WIDTH.
REQ-012 Latency from input to count SHALL be one clock.

Reset
REQ-013 On rst, count SHALL be 0 and wrap SHALL be 0; tc therefore evaluates to 0.
REQ-014 rst asserted mid-count SHALL override load and en on the same edge.
REQ-015 The block SHALL contain no asynchronous reset path.

Configuration
REQ-016 The macro MOD_UPDOWN_COUNTER_SAT_EN SHALL select saturating operation.
- When defined, count SHALL hold at MODULUS-1 in up mode and at 0 in down mode instead of wrapping.
- When defined, tc keeps its REQ-007 meaning and wrap SHALL be tied to 0.
- When undefined, the wrap behaviour of REQ-005/006/008 applies.
- The port list SHALL be identical in both builds.

Structure
REQ-017 Package counter_pkg SHALL hold:
- the direction constants DIR_UP = 1 and DIR_DOWN = 0;
- a function computing the terminal value from the direction and MODULUS.
REQ-018 One sub-module, counter_next_val (combinational), SHALL compute the next count, tc, and the boundary-step flag from count, up_dn, and MODULUS.
REQ-019 The top level SHALL hold the count and wrap registers and the rst/load/en priority mux.

Verification
REQ-020 The bench SHALL cover these directed scenarios (WIDTH=4, MODULUS=10, wrap build unless noted):
- Reset: rst=1 for 2 cycles with en=1 -> count=0, wrap=0; first enabled edge after release -> count=1.
- Up wrap: count=9, up_dn=1, en=1 -> tc=1 that cycle; next cycle count=0 and wrap=1 for exactly one cycle.
- Down wrap: count=0, up_dn=0, en=1 -> tc=1; next cycle count=9 and wrap=1.
- Load priority and clamp: load=1 with load_val=12 and en=1 -> count=9, wrap=0; load=1 with load_val=5 -> count=5.
- Direction flip mid-count: count=4, then alternate up_dn each enabled edge -> sequence 5,4,5,4; en=0 -> count holds.
- Saturating build (MOD_UPDOWN_COUNTER_SAT_EN): count=9, up, en=1 for 3 cycles -> count stays 9, tc=1, wrap=0; rst mid-hold -> count=0.
